speicher_arbiter: RTL

Shares one single-ported external memory between the CPU's instruction-fetch port and its load/store port. Sits between the CPU core and the memory controller. Arbitrates simultaneous requests and sequences one memory transaction at a time. Returns completion pulses and registered read data to the requesting port, and aborts transactions the memory never acknowledges.

---
 rtl/speicher_pkg.sv | 20 ++
 rtl/arbiter_prioritaet.sv | 31 +++
 rtl/speicher_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/speicher_pkg.sv
// rtl/speicher_pkg.sv - shared types and defaults for the memory arbiter
package speicher_pkg;

  localparam int ADRESS_BREITE_DEF = 32;
  localparam int DATEN_BREITE_DEF  = 32;

  typedef enum logic [2:0] {
    LEERLAUF,
    INSTR,
    LESEN,
    SCHREIBEN,
    FERTIG
  } zustand_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATEN = 1'b1
  } port_e;

endpackage

// File: rtl/arbiter_prioritaet.sv
// rtl/arbiter_prioritaet.sv - fixed-priority grant encoder: store > load > fetch
module arbiter_prioritaet
  import speicher_pkg::*;
(
  input  logic lese_instruktion,
  input  logic lese_daten,
  input  logic schreibe_daten,
  output logic grant_gueltig,
  output logic grant_port,
  output logic grant_schreiben
);

  // A simultaneous load is dropped when a store is present.
  always_comb begin
    grant_gueltig   = 1'b0;
    grant_port      = PORT_INSTR;
    grant_schreiben = 1'b0;
    if (schreibe_daten) begin
      grant_gueltig   = 1'b1;
      grant_port      = PORT_DATEN;
      grant_schreiben = 1'b1;
    end else if (lese_daten) begin
      grant_gueltig = 1'b1;
      grant_port    = PORT_DATEN;
    end else if (lese_instruktion) begin
      grant_gueltig = 1'b1;
      grant_port    = PORT_INSTR;
    end
  end

endmodule

// File: rtl/speicher_arbiter.sv
// rtl/speicher_arbiter.sv - shares one memory between fetch and load/store ports
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int ADRESS_BREITE = ADRESS_BREITE_DEF,
  parameter int DATEN_BREITE  = DATEN_BREITE_DEF,
  parameter int TIMEOUT       = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [ADRESS_BREITE-1:0] InstruktionAdresse,
  input  logic                     LeseInstruktion,
  output logic [DATEN_BREITE-1:0]  Instruktion,
  output logic                     InstruktionGeladen,
  input  logic [ADRESS_BREITE-1:0] DatenAdresse,
  input  logic [DATEN_BREITE-1:0]  DatenRaus,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  output logic [DATEN_BREITE-1:0]  DatenRein,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] MemAdresse,
  output logic [DATEN_BREITE-1:0]  MemDatenSchreiben,
  output logic                     MemLesen,
  output logic                     MemSchreiben,
  input  logic [DATEN_BREITE-1:0]  MemDatenLesen,
  input  logic                     MemBereit,
  output logic                     Zeitueberschreitung
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  zustand_e                 state_q, state_d;
  logic [ADRESS_BREITE-1:0] adr_q, adr_d;
  logic [DATEN_BREITE-1:0]  wdat_q, wdat_d;
  logic [DATEN_BREITE-1:0]  instr_q, instr_d;
  logic [DATEN_BREITE-1:0]  drein_q, drein_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic lesen_q, lesen_d, schreiben_q, schreiben_d;
  logic igel_q, igel_d, dgel_q, dgel_d, dgesp_q, dgesp_d;
  logic flag_q, flag_d;

  logic grant_gueltig, grant_port, grant_schreiben;
  logic timeout_hit;
  logic [DATEN_BREITE-1:0] rdaten;

  arbiter_prioritaet u_prio (
    .lese_instruktion (LeseInstruktion),
    .lese_daten       (LeseDaten),
    .schreibe_daten   (SchreibeDaten),
    .grant_gueltig    (grant_gueltig),
    .grant_port       (grant_port),
    .grant_schreiben  (grant_schreiben)
  );

  // A late MemBereit on the last allowed busy cycle still wins over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST) && !MemBereit;
  assign rdaten      = MemBereit ? MemDatenLesen : '0;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    instr_d     = instr_q;
    drein_d     = drein_q;
    cnt_d       = cnt_q;
    lesen_d     = lesen_q;
    schreiben_d = schreiben_q;
    igel_d      = 1'b0;
    dgel_d      = 1'b0;
    dgesp_d     = 1'b0;
    flag_d      = flag_q;
    case (state_q)
      LEERLAUF: begin
        if (grant_gueltig) begin
          cnt_d = '0;
          adr_d = (grant_port == PORT_INSTR) ? InstruktionAdresse : DatenAdresse;
          if (grant_schreiben) begin
            wdat_d      = DatenRaus;
            schreiben_d = 1'b1;
            state_d     = SCHREIBEN;
          end else begin
            lesen_d = 1'b1;
            state_d = (grant_port == PORT_INSTR) ? INSTR : LESEN;
          end
        end
      end
      INSTR, LESEN, SCHREIBEN: begin
        if (MemBereit || timeout_hit) begin
          lesen_d     = 1'b0;
          schreiben_d = 1'b0;
          state_d     = FERTIG;
          if (timeout_hit) flag_d = 1'b1;
          case (state_q)
            INSTR: begin
              instr_d = rdaten;
              igel_d  = 1'b1;
            end
            LESEN: begin
              drein_d = rdaten;
              dgel_d  = 1'b1;
            end
            default: dgesp_d = 1'b1;
          endcase
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FERTIG:  state_d = LEERLAUF;
      default: state_d = LEERLAUF;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= LEERLAUF;
      adr_q       <= '0;
      wdat_q      <= '0;
      instr_q     <= '0;
      drein_q     <= '0;
      cnt_q       <= '0;
      lesen_q     <= 1'b0;
      schreiben_q <= 1'b0;
      igel_q      <= 1'b0;
      dgel_q      <= 1'b0;
      dgesp_q     <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      instr_q     <= instr_d;
      drein_q     <= drein_d;
      cnt_q       <= cnt_d;
      lesen_q     <= lesen_d;
      schreiben_q <= schreiben_d;
      igel_q      <= igel_d;
      dgel_q      <= dgel_d;
      dgesp_q     <= dgesp_d;
      flag_q      <= flag_d;
    end
  end

  assign Instruktion         = instr_q;
  assign InstruktionGeladen  = igel_q;
  assign DatenRein           = drein_q;
  assign DatenGeladen        = dgel_q;
  assign DatenGespeichert    = dgesp_q;
  assign MemAdresse          = adr_q;
  assign MemDatenSchreiben   = wdat_q;
  assign MemLesen            = lesen_q;
  assign MemSchreiben        = schreiben_q;
  assign Zeitueberschreitung = flag_q;

endmodule
